// File: rtl/rr_arb_pkg.sv
// Shared constants, FSM state type and helpers for the 8-way round-robin arbiter.
package rr_arb_pkg;

    localparam int unsigned NREQ = 8;
    localparam int unsigned IDXW = 3;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    function automatic logic [NREQ-1:0] onehot8(input logic [IDXW-1:0] idx);
        onehot8      = '0;
        onehot8[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Rotating-priority 8-to-3 encoder: first set req bit scanning from ptr upward (mod 8).
module rr_pick8
    import rr_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic            any,
    output logic [IDXW-1:0] idx
);

    logic [NREQ-1:0] rot;
    logic [IDXW-1:0] off;

    // Rotating right by ptr puts requester ptr at bit 0, so the lowest set bit wins.
    always_comb begin
        rot = NREQ'({req, req} >> ptr);
        off = '0;
        for (int unsigned i = NREQ; i > 0; i--) begin
            if (rot[i-1]) off = IDXW'(i - 1);
        end
    end

    assign any = |req;
    assign idx = off + ptr;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with hold-until-release grants.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter8
    import rr_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned RST_PTR  = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            e,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_vld,
    output logic            tmo
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255 || RST_PTR > 7) begin : g_param_check
        $error("rr_arbiter8: MAX_HOLD or RST_PTR out of range");
    end

    state_t          state;
    logic [IDXW-1:0] ptr;
    logic            tmo_q;
    logic            pick_any;
    logic [IDXW-1:0] pick_idx;
    logic            owner_rel;
    logic            hold_limit;

    rr_pick8 u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign owner_rel = done | ~req[gnt_idx];

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;

    // Held at zero while idle, so the first GRANT cycle sees 0.
    always_ff @(posedge clk) begin
        if (rst || state == ST_IDLE) hold_cnt <= '0;
        else                         hold_cnt <= hold_cnt + 8'd1;
    end

    assign hold_limit = (hold_cnt == 8'(MAX_HOLD - 1));
`else
    assign hold_limit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            ptr     <= IDXW'(RST_PTR);
            tmo_q   <= 1'b0;
        end else begin
            tmo_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (e && pick_any) begin
                        state   <= ST_GRANT;
                        gnt     <= onehot8(pick_idx);
                        gnt_idx <= pick_idx;
                    end
                end
                ST_GRANT: begin
                    if (owner_rel || hold_limit) begin
                        state <= ST_IDLE;
                        gnt   <= '0;
                        ptr   <= gnt_idx + 3'd1;
                        tmo_q <= ~owner_rel;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign gnt_vld = (state == ST_GRANT);
    assign tmo     = tmo_q;

endmodule
